// File: rtl/mcpu5_run_ctrl_if.sv
// Host load port and MCPU5 core bus shared by the run controller and its environment.
// The master side is the host/core; the slave side is the run controller.
interface mcpu5_run_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [5:0]        load_data;
    logic              cpu_rst;
    logic [5:0]        cpu_inst;
    logic [7:0]        cpu_addr;

    modport master (
        output load_valid, load_addr, load_data, cpu_addr,
        input  load_ready, cpu_rst, cpu_inst
    );

    modport slave (
        input  load_valid, load_addr, load_data, cpu_addr,
        output load_ready, cpu_rst, cpu_inst
    );
endinterface

// File: rtl/mcpu5_run_ctrl.sv
// Run controller for the MCPU5 core: owns the program store, sequences core reset,
// feeds instructions, captures OUT results, counts cycles and enforces a watchdog.
module mcpu5_run_ctrl #(
    parameter int          ADDR_W     = 8,
    parameter int          RST_CYCLES = 2,
    parameter int          MAX_CYCLES = 10000,
    parameter int          CYC_W      = 16,
    parameter logic [5:0]  OUT_OPCODE = 6'b111011,
    parameter logic [5:0]  IDLE_INST  = 6'b111001
) (
    input  logic              clk,
    input  logic              reset,
    mcpu5_run_ctrl_if.slave   bus,
    input  logic              start,
    input  logic              stop,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycles
);
    localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CYC_W-1:0]  cycles_q, cycles_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              pend_q, pend_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              ready_q, ready_d;

    logic [5:0]        mem [2**ADDR_W];
    logic [5:0]        cpu_inst_w;
    logic [CYC_W:0]    cyc_inc;
    logic              wd_hit;
    logic              wr_en;

    // Zero-latency store read: the core sees its instruction in the same cycle it presents the address.
    assign cpu_inst_w     = (state_q == S_RUN) ? mem[bus.cpu_addr[ADDR_W-1:0]] : IDLE_INST;
    assign bus.cpu_inst   = cpu_inst_w;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.load_ready = ready_q && !reset;
    assign wr_en          = bus.load_valid && bus.load_ready;

    assign cyc_inc = {1'b0, cycles_q} + (CYC_W+1)'(1);
    assign wd_hit  = cyc_inc >= (CYC_W+1)'(MAX_CYCLES);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycles_d    = cycles_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        // Capture completes one edge after the OUT, in whatever state we are then in.
        out_valid_d = pend_q;
        out_data_d  = pend_q ? bus.cpu_addr : out_data_q;
        pend_d      = (state_q == S_RUN) && (cpu_inst_w == OUT_OPCODE);

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d   = S_RST;
                    rst_cnt_d = RC_W'(RST_CYCLES);
                    cycles_d  = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_RST: begin
                if (stop) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else if (rst_cnt_q == RC_W'(1)) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RC_W'(1);
                end
            end
            S_RUN: begin
                if (!cyc_inc[CYC_W]) begin
                    cycles_d = cyc_inc[CYC_W-1:0];
                end
                // Watchdog wins the timeout flag when it coincides with stop.
                if (wd_hit || stop) begin
                    state_d   = S_HALT;
                    done_d    = 1'b1;
                    timeout_d = wd_hit;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d == S_RST) || (state_d == S_RUN);
        cpu_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_IDLE) || (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            cpu_rst_q   <= 1'b1;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycles_q    <= cycles_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            cpu_rst_q   <= cpu_rst_d;
            ready_q     <= ready_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;
endmodule

// File: tb/tb_mcpu5_run_ctrl.sv
// Bench for mcpu5_run_ctrl: a hand-written vector table, directed corner sequences and
// randomized traffic checked every cycle against a behavioural model of the run controller.
module tb_mcpu5_run_ctrl;
    localparam int         ADDR_W = 8;
    localparam int         RSTC   = 2;
    localparam int         MAXC   = 20;
    localparam int         CYC_W  = 16;
    localparam logic [5:0] OUTOP  = 6'h3B;
    localparam logic [5:0] IDLEI  = 6'h39;

    logic clk;
    logic reset;
    logic start, stop;
    logic [7:0] out_data;
    logic out_valid, busy, done, timeout;
    logic [CYC_W-1:0] cycles;

    mcpu5_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    mcpu5_run_ctrl #(
        .ADDR_W(ADDR_W), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .CYC_W(CYC_W),
        .OUT_OPCODE(OUTOP), .IDLE_INST(IDLEI)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .start(start), .stop(stop),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .done(done),
        .timeout(timeout), .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus registers
    logic       r_rst, r_st, r_sp, r_lv;
    logic [7:0] r_la, r_ca;
    logic [5:0] r_ld;
    assign reset          = r_rst;
    assign start          = r_st;
    assign stop           = r_sp;
    assign bus.load_valid = r_lv;
    assign bus.load_addr  = r_la;
    assign bus.load_data  = r_ld;
    assign bus.cpu_addr   = r_ca;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the controller
    typedef enum {PH_IDLE, PH_RST, PH_RUN, PH_HALT} phase_e;
    phase_e     ph;
    int         rst_seen, m_cyc;
    bit         m_done, m_to, m_ov, m_pend;
    logic [7:0] m_od;
    logic [5:0] m_mem [256];

    function automatic logic [5:0] m_inst();
        return (ph == PH_RUN) ? m_mem[r_ca] : IDLEI;
    endfunction

    function automatic bit m_ready();
        return !r_rst && (ph == PH_IDLE || ph == PH_HALT);
    endfunction

    task automatic model_reset();
        ph = PH_IDLE; m_cyc = 0; m_done = 0; m_to = 0; m_ov = 0; m_pend = 0; m_od = 8'h00;
    endtask

    task automatic model_edge();
        logic [5:0] inst;
        inst = m_inst();
        if (r_rst) begin
            model_reset();
        end else begin
            if (r_lv && m_ready()) m_mem[r_la] = r_ld;
            m_ov = m_pend;
            if (m_pend) m_od = r_ca;
            m_pend = (ph == PH_RUN) && (inst == OUTOP);
            case (ph)
                PH_IDLE, PH_HALT: if (r_st) begin
                    ph = PH_RST; rst_seen = 0; m_cyc = 0; m_done = 0; m_to = 0;
                end
                PH_RST: begin
                    if (r_sp) begin
                        ph = PH_HALT; m_done = 1;
                    end else begin
                        rst_seen++;
                        if (rst_seen == RSTC) ph = PH_RUN;
                    end
                end
                PH_RUN: begin
                    if (m_cyc < (1 << CYC_W) - 1) m_cyc++;
                    if (m_cyc >= MAXC) begin
                        ph = PH_HALT; m_done = 1; m_to = 1;
                    end else if (r_sp) begin
                        ph = PH_HALT; m_done = 1; m_to = 0;
                    end
                end
                default: ph = PH_IDLE;
            endcase
        end
    endtask

    task automatic check_model();
        chk("cpu_rst",    bus.cpu_rst,    ph != PH_RUN);
        chk("cpu_inst",   bus.cpu_inst,   m_inst());
        chk("busy",       busy,           ph == PH_RST || ph == PH_RUN);
        chk("load_ready", bus.load_ready, m_ready());
        chk("out_valid",  out_valid,      m_ov);
        chk("out_data",   out_data,       m_od);
        chk("done",       done,           m_done);
        chk("timeout",    timeout,        m_to);
        chk("cycles",     cycles,         m_cyc);
    endtask

    // One clock cycle: drive inputs, compare mid-cycle, advance model at the edge.
    task automatic step(input bit rs, input bit st, input bit sp, input bit lv,
                        input logic [7:0] la, input logic [5:0] ld, input logic [7:0] ca,
                        input bit chk_m);
        r_rst = rs; r_st = st; r_sp = sp; r_lv = lv; r_la = la; r_ld = ld; r_ca = ca;
        @(negedge clk);
        if (chk_m) check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_start();
        step(0, 1, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1);
    endtask

    typedef struct {
        bit rs, st, sp, lv;
        logic [7:0] la;
        logic [5:0] ld;
        logic [7:0] ca;
        bit e_crst;
        logic [5:0] e_inst;
        bit e_busy, e_lr, e_ov;
        logic [7:0] e_od;
        bit e_done, e_to;
        int e_cyc;
    } vec_t;

    function automatic vec_t mk(bit rs, bit st, bit sp, bit lv, logic [7:0] la, logic [5:0] ld,
                                logic [7:0] ca, bit ecr, logic [5:0] ei, bit eb, bit elr,
                                bit eov, logic [7:0] eod, bit ed, bit eto, int ec);
        vec_t v;
        v.rs = rs; v.st = st; v.sp = sp; v.lv = lv; v.la = la; v.ld = ld; v.ca = ca;
        v.e_crst = ecr; v.e_inst = ei; v.e_busy = eb; v.e_lr = elr; v.e_ov = eov;
        v.e_od = eod; v.e_done = ed; v.e_to = eto; v.e_cyc = ec;
        return v;
    endfunction

    vec_t tv[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit rs, st, sp, lv;
        logic [7:0] la, ca;
        logic [5:0] ld;

        // Reset and fill the whole store with 00 so every address reads back defined.
        r_rst = 1; r_st = 0; r_sp = 0; r_lv = 0; r_la = 0; r_ld = 0; r_ca = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int a = 0; a < 256; a++) step(0, 0, 0, 1, 8'(a), 6'h00, 8'h00, 1);

        //      rs st sp lv la     ld     ca      crst inst  busy lr ov od     dn to cyc
        tv.push_back(mk(1, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 0, 0, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8'h00, 6'h01, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8'h01, 6'h02, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8'h02, 6'h3B, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8'h03, 6'h04, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8'h05, 6'h3B, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 1, 8'h06, 6'h3B, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 0, 1, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 1, 0, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 1, 0, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 0, 6'h01, 1, 0, 0, 8'h00, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h01, 0, 6'h02, 1, 0, 0, 8'h00, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h02, 0, 6'h3B, 1, 0, 0, 8'h00, 0, 0, 2));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h2A, 0, 6'h00, 1, 0, 0, 8'h00, 0, 0, 3));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h03, 0, 6'h04, 1, 0, 1, 8'h2A, 0, 0, 4));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h05, 0, 6'h3B, 1, 0, 0, 8'h2A, 0, 0, 5));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h06, 0, 6'h3B, 1, 0, 0, 8'h2A, 0, 0, 6));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h80, 0, 6'h00, 1, 0, 1, 8'h06, 0, 0, 7));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 0, 6'h01, 1, 0, 1, 8'h80, 0, 0, 8));
        tv.push_back(mk(0, 0, 1, 0, 8'h00, 6'h00, 8'h01, 0, 6'h02, 1, 0, 0, 8'h80, 0, 0, 9));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h02, 1, 6'h39, 0, 1, 0, 8'h80, 1, 0, 10));
        tv.push_back(mk(0, 1, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 0, 1, 0, 8'h80, 1, 0, 10));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 1, 0, 0, 8'h80, 0, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 1, 0, 0, 8'h80, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1, 6'h39, 0, 1, 0, 8'h80, 1, 0, 0));

        foreach (tv[i]) begin
            r_rst = tv[i].rs; r_st = tv[i].st; r_sp = tv[i].sp; r_lv = tv[i].lv;
            r_la = tv[i].la; r_ld = tv[i].ld; r_ca = tv[i].ca;
            @(negedge clk);
            chk("v_cpu_rst",    bus.cpu_rst,    tv[i].e_crst);
            chk("v_cpu_inst",   bus.cpu_inst,   tv[i].e_inst);
            chk("v_busy",       busy,           tv[i].e_busy);
            chk("v_load_ready", bus.load_ready, tv[i].e_lr);
            chk("v_out_valid",  out_valid,      tv[i].e_ov);
            chk("v_out_data",   out_data,       tv[i].e_od);
            chk("v_done",       done,           tv[i].e_done);
            chk("v_timeout",    timeout,        tv[i].e_to);
            chk("v_cycles",     cycles,         tv[i].e_cyc);
            $display("vec %0d: ca=%02h inst=%02h busy=%0b ov=%0b od=%02h done=%0b cyc=%0d",
                     i, r_ca, bus.cpu_inst, busy, out_valid, out_data, done, cycles);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Watchdog with a program that never stops.
        run_start();
        for (int i = 0; i < 25; i++) step(0, 0, 0, 0, 8'h00, 6'h00, 8'($urandom_range(0, 15)), 1);
        chk("wd_cycles", cycles, 32'd20);
        chk("wd_done", done, 1);
        chk("wd_timeout", timeout, 1);
        chk("wd_cpu_rst", bus.cpu_rst, 1);
        chk("wd_cpu_inst", bus.cpu_inst, 6'h39);
        $display("seq watchdog: cycles=%0d timeout=%0b", cycles, timeout);

        // Stop coinciding with the watchdog edge, with an OUT pending at that final edge.
        run_start();
        for (int i = 0; i < 19; i++) step(0, 0, 0, 0, 8'h00, 6'h00, 8'h03, 1);
        step(0, 0, 1, 0, 8'h00, 6'h00, 8'h05, 1);
        r_ca = 8'h4D;
        #1;
        chk("wdstop_cycles", cycles, 32'd20);
        chk("wdstop_timeout", timeout, 1);
        chk("wdstop_done", done, 1);
        step(0, 0, 0, 0, 8'h00, 6'h00, 8'h4D, 1);
        chk("halt_capture_valid", out_valid, 1);
        chk("halt_capture_data", out_data, 8'h4D);
        step(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        $display("seq stop+watchdog: timeout=%0b out_data=%02h", timeout, out_data);

        // Stop at RUN cycle 5, then restart.
        run_start();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        step(0, 0, 1, 0, 8'h00, 6'h00, 8'h01, 1);
        chk("stop_cycles", cycles, 32'd5);
        chk("stop_timeout", timeout, 0);
        chk("stop_done", done, 1);
        step(0, 1, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        chk("restart_done", done, 0);
        chk("restart_cycles", cycles, 32'd0);
        step(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        step(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 6'h00, 8'h01, 1);
        step(0, 0, 1, 0, 8'h00, 6'h00, 8'h00, 1);
        $display("seq stop/restart: cycles=%0d", cycles);

        // Reset in the middle of a run with a capture in flight.
        run_start();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00, 6'h00, 8'h02, 1);
        step(1, 0, 0, 0, 8'h00, 6'h00, 8'h02, 1);
        r_rst = 0;
        #1;
        chk("mreset_busy", busy, 0);
        chk("mreset_cpu_rst", bus.cpu_rst, 1);
        chk("mreset_cpu_inst", bus.cpu_inst, 6'h39);
        chk("mreset_out_valid", out_valid, 0);
        chk("mreset_out_data", out_data, 8'h00);
        chk("mreset_cycles", cycles, 32'd0);
        chk("mreset_ready", bus.load_ready, 1);
        step(0, 0, 0, 0, 8'h00, 6'h00, 8'h00, 1);
        $display("seq mid-run reset: busy=%0b out_data=%02h", busy, out_data);

        // Load attempts during RUN must be refused and leave the store untouched.
        run_start();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 8'h00, 6'h15, 8'h03, 1);
            chk("run_ready_low", bus.load_ready, 0);
        end
        step(0, 0, 1, 0, 8'h00, 6'h00, 8'h00, 1);
        run_start();
        r_ca = 8'h00;
        #1;
        chk("store_kept", bus.cpu_inst, 6'h01);
        step(0, 0, 1, 0, 8'h00, 6'h00, 8'h00, 1);
        $display("seq load-in-run: store[0] read back");

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rs = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 29) == 0);
            lv = 1'($urandom_range(0, 1));
            la = 8'($urandom_range(0, 15));
            ld = ($urandom_range(0, 3) == 0) ? OUTOP : 6'($urandom);
            ca = 8'($urandom);
            if ($urandom_range(0, 1) == 1) ca = ca & 8'h0F;
            step(rs, st, sp, lv, la, ld, ca, 1);
        end
        $display("seq random: 2000 cycles applied");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
